// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops via IDLE->DONE, optional WIDTH-cycle shift-and-add MUL.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise opcode 11 reports illegal.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
  typedef enum logic {IDLE, DONE} state_t;
`endif

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL1 = 4'd6,
    OP_SHR1 = 4'd7,
    OP_SHLB = 4'd8,
    OP_SHRB = 4'd9,
    OP_ASRB = 4'd10,
    OP_MUL  = 4'd11
  } op_t;

  state_t state, state_nxt;
  logic   accept;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;
  logic [3:0]       alu_flags;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl_t, shr_t;
  logic signed [WIDTH:0] asr_t;

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               mul_last;

  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CW'(WIDTH - 1));
`endif

  assign accept = in_valid & in_ready;

  // Shifts use a one-bit extension so the last bit shifted out lands in a fixed position.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    sum     = '0;
    shl_t   = '0;
    shr_t   = '0;
    asr_t   = '0;
    case (opcode)
      OP_ADD: begin
        sum     = {1'b0, a} + {1'b0, b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, a} - {1'b0, b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_SHL1: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      OP_SHR1: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      OP_SHLB: begin
        shl_t   = {1'b0, a} << b;
        alu_res = shl_t[WIDTH-1:0];
        alu_c   = shl_t[WIDTH];
      end
      OP_SHRB: begin
        shr_t   = {a, 1'b0} >> b;
        alu_res = shr_t[WIDTH:1];
        alu_c   = shr_t[0];
      end
      OP_ASRB: begin
        asr_t   = $signed({a, 1'b0}) >>> b;
        alu_res = asr_t[WIDTH:1];
        alu_c   = asr_t[0];
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  alu_ill = 1'b0;
`endif
      default: alu_ill = 1'b1;
    endcase
    alu_flags = alu_ill ? 4'b0000 : {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (opcode == OP_MUL) state_nxt = MUL;
          else                  state_nxt = DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL:     if (mul_last) state_nxt = DONE;
`endif
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= '0;
      flags   <= '0;
      illegal <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (opcode == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              result  <= alu_res;
              flags   <= alu_flags;
              illegal <= alu_ill;
            end
`else
            result  <= alu_ill ? '0 : alu_res;
            flags   <= alu_flags;
            illegal <= alu_ill;
`endif
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (mul_last) begin
            result  <= acc_nxt[WIDTH-1:0];
            flags   <= {(acc_nxt[WIDTH-1:0] == '0), acc_nxt[WIDTH-1],
                        (|acc_nxt[2*WIDTH-1:WIDTH]), 1'b0};
            illegal <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8): vector table driven through a scoreboard queue,
// plus hand sequences for reset during MUL/DONE. Expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
  localparam int W = 8;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [W-1:0] a, b, result;
  logic [3:0]   opcode, flags;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .illegal(illegal)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   fl;
    logic         ill;
    int           lat;
    int           hold;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;
    logic         ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                     input logic [W-1:0] res, input logic [3:0] fl, input logic ill,
                     input int hold);
    vec_t v;
    v.op = op; v.a = va; v.b = vb; v.res = res; v.fl = fl; v.ill = ill;
    v.lat  = (op == 4'd11 && MUL_ON) ? W + 1 : 1;
    v.hold = hold;
    vecs.push_back(v);
  endtask

  // Issue one command, keep in_valid high with junk while busy, optionally stall out_ready.
  task automatic do_op(input vec_t v, input string tag);
    exp_t e, got;
    int   lat;
    bit   busy_ok, hold_ok;
    chk({tag, " in_ready_idle"}, in_ready, 1);
    a = v.a; b = v.b; opcode = v.op; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    e.res = v.res; e.fl = v.fl; e.ill = v.ill;
    sbq.push_back(e);
    a = W'($urandom); b = W'($urandom); opcode = 4'($urandom);
    out_ready = (v.lat > 1);
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    chk({tag, " latency"}, lat, v.lat);
    if (v.lat > 1) chk({tag, " in_ready_busy"}, busy_ok, 1);
    hold_ok = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || result !== e.res || flags !== e.fl || illegal !== e.ill)
        hold_ok = 1'b0;
    end
    if (v.hold > 0) chk({tag, " hold_stable"}, hold_ok, 1);
    got = sbq.pop_front();
    chk({tag, " result"},  result,  got.res);
    chk({tag, " flags"},   flags,   got.fl);
    chk({tag, " illegal"}, illegal, got.ill);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid_drop"}, out_valid, 0);
    chk({tag, " in_ready_back"},  in_ready,  1);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " in_ready"},  in_ready,  1);
    chk({tag, " result"},    result,    0);
    chk({tag, " flags"},     flags,     0);
    chk({tag, " illegal"},   illegal,   0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; opcode = '0;

    //   op     a      b      res    {Z,N,C,V} ill hold
    add(4'd0,  8'hFF, 8'h01, 8'h00, 4'b1010, 0, 0);
    add(4'd1,  8'h80, 8'h01, 8'h7F, 4'b0001, 0, 0);
    add(4'd10, 8'h90, 8'h03, 8'hF2, 4'b0100, 0, 0);
    add(4'd0,  8'h7F, 8'h01, 8'h80, 4'b0101, 0, 0);
    add(4'd0,  8'h80, 8'h80, 8'h00, 4'b1011, 0, 0);
    add(4'd1,  8'h01, 8'h02, 8'hFF, 4'b0110, 0, 0);
    add(4'd1,  8'h05, 8'h05, 8'h00, 4'b1000, 0, 0);
    add(4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000, 0, 0);
    add(4'd3,  8'h0F, 8'hF0, 8'hFF, 4'b0100, 0, 0);
    add(4'd4,  8'hAA, 8'hAA, 8'h00, 4'b1000, 0, 0);
    add(4'd5,  8'h0F, 8'h00, 8'hF0, 4'b0100, 0, 0);
    add(4'd6,  8'h81, 8'h00, 8'h02, 4'b0010, 0, 0);
    add(4'd7,  8'h81, 8'h00, 8'h40, 4'b0010, 0, 0);
    add(4'd8,  8'h03, 8'h07, 8'h80, 4'b0110, 0, 0);
    add(4'd8,  8'h81, 8'h08, 8'h00, 4'b1010, 0, 0);
    add(4'd8,  8'h81, 8'h09, 8'h00, 4'b1000, 0, 0);
    add(4'd9,  8'h81, 8'h00, 8'h81, 4'b0100, 0, 0);
    add(4'd9,  8'h06, 8'h02, 8'h01, 4'b0010, 0, 0);
    add(4'd9,  8'h81, 8'h08, 8'h00, 4'b1010, 0, 0);
    add(4'd10, 8'h81, 8'd200, 8'hFF, 4'b0110, 0, 0);
    add(4'd10, 8'h40, 8'h08, 8'h00, 4'b1000, 0, 0);
    add(4'd12, 8'h12, 8'h34, 8'h00, 4'b0000, 1, 0);
    add(4'd0,  8'h03, 8'h04, 8'h07, 4'b0000, 0, 5);
    add(4'd15, 8'hFF, 8'hFF, 8'h00, 4'b0000, 1, 2);
    add(4'd0,  8'h01, 8'h01, 8'h02, 4'b0000, 0, 0);
    if (MUL_ON) begin
      add(4'd11, 8'h10, 8'h11, 8'h10, 4'b0010, 0, 0);
      add(4'd11, 8'hFF, 8'hFF, 8'h01, 4'b0010, 0, 3);
      add(4'd11, 8'h03, 8'h05, 8'h0F, 4'b0000, 0, 0);
      add(4'd11, 8'h00, 8'h5A, 8'h00, 4'b1000, 0, 0);
    end else begin
      add(4'd11, 8'h10, 8'h11, 8'h00, 4'b0000, 1, 0);
      add(4'd11, 8'hFF, 8'hFF, 8'h00, 4'b0000, 1, 0);
    end

    // Asynchronous reset takes effect before any clock edge.
    #2 rst = 1'b1;
    #1 reset_check("por");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      do_op(v, $sformatf("vec%0d", i));
    end

    // Reset three cycles into a MUL (or while DONE holds an illegal result).
    a = 8'h10; b = 8'h11; opcode = 4'd11; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1 reset_check("rst_mul");
    sbq.delete();
    @(posedge clk); #1;
    reset_check("rst_mul_hold");
    rst = 1'b0;
    add(4'd0, 8'h21, 8'h12, 8'h33, 4'b0000, 0, 0);
    v = vecs[vecs.size() - 1];
    do_op(v, "after_rst_mul");

    // Reset while DONE presents a result.
    a = 8'h05; b = 8'h06; opcode = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_done pre_valid", out_valid, 1);
    chk("rst_done pre_result", result, 8'h0B);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 reset_check("rst_done");
    @(posedge clk); #1;
    rst = 1'b0;
    add(4'd1, 8'h10, 8'h01, 8'h0F, 4'b0000, 0, 0);
    v = vecs[vecs.size() - 1];
    do_op(v, "after_rst_done");

    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..64.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  operand/opcode presented.
REQ-005 in_ready  out  1  block can accept a command.
REQ-006 a  in  WIDTH  operand A.
REQ-007 b  in  WIDTH  operand B (or shift amount).
REQ-008 opcode  in  4  operation select.
REQ-009 out_valid  out  1  result/flags valid.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 result  out  WIDTH  registered result.
REQ-012 flags  out  4  {Z,N,C,V}, registered.
REQ-013 illegal  out  1  registered; accepted opcode was unsupported.

Function
REQ-014 FSM states IDLE, MUL, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 Accept = in_valid & in_ready; a, b, opcode are captured at accept; later input changes are ignored.
REQ-016 IDLE + accept: MUL opcode -> MUL; any other opcode -> DONE with result/flags registered on the same edge (out_valid one cycle after accept).
REQ-017 Opcodes: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a by 1, 7 SHR a by 1 (logical), 8 SHL a by b, 9 SHR a by b (logical), 10 ASR a by b, 11 MUL, 12-15 illegal.
REQ-018 All arithmetic is modulo 2^WIDTH; b is an unsigned shift amount; amount >= WIDTH gives 0 (SHL/SHR) or all copies of a[WIDTH-1] (ASR).
REQ-019 MUL is shift-and-add, one multiplier bit per cycle, WIDTH cycles in MUL, then DONE; result = low WIDTH bits of a*b (unsigned); out_valid rises WIDTH+1 cycles after accept.
REQ-020 Z = (result==0); N = result[WIDTH-1].
REQ-021 C: ADD carry-out; SUB borrow (a<b unsigned); shift ops the last bit shifted out (0 if amount is 0; for amount > WIDTH, 0 for SHL/SHR and a[WIDTH-1] for ASR); MUL 1 if high half of product is nonzero; logic ops 0.
REQ-022 V: signed overflow for ADD/SUB, 0 for all other ops.
REQ-023 Illegal opcode: result=0, flags=0, illegal=1, latency as single-cycle op; illegal=0 for all legal ops.
REQ-024 DONE holds result, flags, illegal stable until out_ready=1; on that edge -> IDLE and out_valid drops next cycle.
REQ-025 out_ready while not in DONE has no effect; in_valid outside IDLE is ignored (not queued).

Reset
REQ-026 rst asserted: state=IDLE, result=0, flags=0, illegal=0, out_valid=0, in_ready=1, MUL accumulator/counter cleared, immediately and regardless of clk.
REQ-027 Reset during MUL or DONE discards the operation; no partial result is ever presented.
REQ-028 First accept possible on the first rising clk edge after rst deasserts.

Configuration
REQ-029 Macro ALU_SEQ_MUL_EN: when defined, opcode 11 is MUL per REQ-019.
REQ-030 ALU_SEQ_MUL_EN undefined: the MUL state and datapath are absent; opcode 11 is treated as illegal per REQ-023.

Verification (WIDTH=8)
REQ-031 ADD a=0xFF b=0x01 -> result 0x00, flags Z=1 N=0 C=1 V=0, out_valid 1 cycle after accept.
REQ-032 SUB a=0x80 b=0x01 -> result 0x7F, Z=0 N=0 C=0 V=1; ASR a=0x90 b=3 -> result 0xF2, N=1 C=0.
REQ-033 MUL a=0x10 b=0x11 (macro defined) -> result 0x10, C=1, out_valid 9 cycles after accept, in_ready=0 throughout; with macro undefined -> result 0x00, illegal=1.
REQ-034 ADD a=0x03 b=0x04 with out_ready held 0 for 5 cycles -> result 0x07 stable, out_valid=1, in_ready=0 for all 5; release -> IDLE next cycle.
REQ-035 Assert rst 3 cycles into a MUL -> out_valid=0, result=0, in_ready=1 immediately; next command completes normally.
REQ-036 opcode 0xC -> result 0x00, flags 0, illegal=1; following ADD clears illegal to 0.
